uart_core_8n1: RTL and testbench
================================

# uart_core_8n1

8N1 UART transceiver feeding the UART control stage: deserialises the `rx` pin into bytes presented on `data_out` with `rxrdy`, and serialises bytes written through `data_in`/`wen` onto `tx`. The control stage supplies the baud settings (`baud_val` = 26, `baud_val_frac` = 1), acknowledges received bytes with active-low `oen`, and launches transmit bytes with active-low `wen`. One clock domain; `rx` is the only asynchronous input.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `rx` before use; legal values ≥ 2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `baud_val` in 13: 16x tick period minus one, in clocks.
- `baud_val_frac` in 3: fractional period extension, in eighths of a clock.
- `rx` in 1: serial input, idle high.
- `tx` out 1: serial output, idle high.
- `data_in` in 8: byte to transmit.
- `wen` in 1: active-low write strobe.
- `txrdy` out 1: transmitter idle; a write is accepted.
- `data_out` out 8: last received byte.
- `rxrdy` out 1: unread byte is present on `data_out`.
- `oen` in 1: active-low read acknowledge.
- `framing_err` out 1: stop bit of the current byte was sampled low.
- `overflow` out 1: a byte completed while `rxrdy` was already set.

## Operation
- **Baud generator.**
  - A down-counter reloads from `baud_val` and emits a 1-clock `tick` on reaching 0.
  - On each reload, a 3-bit accumulator adds `baud_val_frac`. On carry-out, the next period is one clock longer.
  - Nominal tick period is `baud_val`+1+`baud_val_frac`/8 clocks.
  - New `baud_val`/`baud_val_frac` values take effect at the next reload. Changing them mid-frame is unsupported.
- **RX FSM** (states IDLE, START, DATA, STOP; 4-bit tick counter; 3-bit bit index).
  - IDLE → START when the synchronised `rx` is 0 on a tick. The tick counter clears.
  - START: after 8 ticks, sample `rx`. If it is 1 (false start), go to IDLE. If it is 0, clear the counter and go to DATA.
  - DATA: every 16 ticks, shift the sample into bit index 0..7, LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample the stop bit and go directly to IDLE, so back-to-back frames work.
  - The stop-bit sample loads `data_out` and sets `rxrdy`. `framing_err` takes the inverted stop sample.
  - The byte is delivered even when `framing_err` is set.
- **RX handshake.**
  - `oen`=0 sampled on a clock edge clears `rxrdy`, `framing_err` and `overflow` on that edge.
  - Holding `oen` low for several cycles is harmless.
  - Completion while `rxrdy`=1: `data_out` is overwritten with the newest byte and `overflow` sets.
  - Completion on the same edge as `oen`=0: completion wins. `rxrdy` stays 1 and `overflow` is not set.
- **TX FSM** (states IDLE, START, DATA, STOP).
  - Load condition: `wen` falls (registered previous `wen`=1, current `wen`=0) while `txrdy`=1.
  - On load: `data_in` is latched, `txrdy` drops the next cycle, and the state moves to START.
  - `wen` held low does not retrigger. A falling edge while `txrdy`=0 is ignored.
  - Each state drives `tx` for 16 ticks: start bit 0, then 8 data bits LSB first, then stop bit 1.
  - At the end of STOP, go to IDLE and raise `txrdy`.
- **Reset values:** `tx`=1, `txrdy`=1, `rxrdy`=0, `data_out`=0, `framing_err`=0, `overflow`=0; both FSMs in IDLE; baud counter loaded with 0; accumulator 0; `rx` synchroniser preset to 1.
- Reset mid-frame aborts both directions immediately with no partial byte.

## Timing
- Bit time is 16 ticks. With `baud_val`=26 and `baud_val_frac`=1, the tick is 27.125 clocks and the bit is 434 clocks.
- `rxrdy` rises 1 clock after the tick that samples the stop bit. The `rx` edge reaches the FSM `SYNC_STAGES` clocks late.
- `tx` falls to the start bit on the first tick after load. It therefore lags the `wen` falling edge by at most one tick period + 1 clock.
- `txrdy` rises on the clock after the final stop-bit tick.
- `rxrdy` clears 1 clock after `oen` is sampled low.

## Structure
- Package `uart_pkg`:
  - `OVERSAMPLE` = 16, `DATA_BITS` = 8.
  - RX and TX state typedefs.
  - `uart_rx_state_t`, `uart_tx_state_t`.
- Sub-module `uart_baud_gen`: counter plus fractional accumulator, outputting `tick`. RX and TX share one instance.
- The RX and TX FSMs live in this module.

## Test plan
- Baud: `baud_val`=26, `baud_val_frac`=1 → 8 consecutive tick periods sum to exactly 217 clocks (one 28-clock period); `baud_val`=3, `baud_val_frac`=0 → tick every 4 clocks.
- RX byte 0xA5 at 434 clocks/bit → `data_out`=0xA5 and `rxrdy`=1, `framing_err`=0; `oen` low for 4 clocks → `rxrdy`=0 on the next clock.
- Four back-to-back frames 0xDE, 0xAD, 0xBE, 0xEF, each read before the next stop bit → four `rxrdy` pulses with matching bytes and no errors.
- Two frames 0x11, 0x22 with no read → `data_out`=0x22, `overflow`=1; a 10-clock `rx` low glitch → no state change; stop bit forced 0 on 0x3C → `framing_err`=1 and `data_out`=0x3C.
- `wen` low for 5 clocks with `data_in`=0x5A → exactly one frame on `tx` (0, 0,1,0,1,1,0,1,0, 1), `txrdy` low for 10×434 clocks ±1; a second `wen` edge mid-frame is ignored.
- `reset_n` low mid-RX and mid-TX → `tx`=1, `txrdy`=1, `rxrdy`=0 immediately; the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state types for the 8N1 UART core.
// Oversampling and frame geometry live here so both FSMs agree on them.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int TICK_CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_IDX_W  = $clog2(DATA_BITS);

   localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(OVERSAMPLE - 1);
   localparam logic [TICK_CNT_W-1:0] TICK_HALF = TICK_CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_CNT_W-1:0] TICK_ONE  = TICK_CNT_W'(1);
   localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic [BIT_IDX_W-1:0]  BIT_ONE   = BIT_IDX_W'(1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator: integer down-counter with a 3-bit
// fractional accumulator that stretches one period per carry-out.
module uart_baud_gen (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [12:0] baud_val,
   input  logic [2:0]  baud_val_frac,
   output logic        tick
);

   logic [13:0] cnt_q;
   logic [2:0]  acc_q;
   logic [3:0]  acc_sum;

   assign tick    = (cnt_q == 14'd0);
   assign acc_sum = {1'b0, acc_q} + {1'b0, baud_val_frac};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 14'd0;
         acc_q <= 3'd0;
      end else if (tick) begin
         acc_q <= acc_sum[2:0];
         cnt_q <= {1'b0, baud_val} + 14'(acc_sum[3]);
      end else begin
         cnt_q <= cnt_q - 14'd1;
      end
   end

endmodule

// File: rtl/uart_core_8n1.sv
// 8N1 UART transceiver: synchronised RX deserialiser with a read handshake,
// and a TX serialiser launched by a falling edge on the write strobe.
module uart_core_8n1 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [12:0] baud_val,
   input  logic [2:0]  baud_val_frac,
   input  logic        rx,
   output logic        tx,
   input  logic [7:0]  data_in,
   input  logic        wen,
   output logic        txrdy,
   output logic [7:0]  data_out,
   output logic        rxrdy,
   input  logic        oen,
   output logic        framing_err,
   output logic        overflow
);
   import uart_pkg::*;

   logic tick;

   uart_baud_gen u_baud (
      .clk          (clk),
      .reset_n      (reset_n),
      .baud_val     (baud_val),
      .baud_val_frac(baud_val_frac),
      .tick         (tick)
   );

   // ---------------- RX path ----------------
   logic [SYNC_STAGES-1:0] rx_sync_q;
   logic                   rx_s;

   // Preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rx_sync_q <= '1;
      else          rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = rx_sync_q[SYNC_STAGES-1];

   uart_rx_state_t         rx_state_q, rx_state_d;
   logic [TICK_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [BIT_IDX_W-1:0]   rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic                   rx_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      if (tick) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_state_d = RX_START;
                  rx_cnt_d   = '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == TICK_HALF) begin
                  rx_cnt_d   = '0;
                  rx_idx_d   = '0;
                  rx_state_d = rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + TICK_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == TICK_LAST) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                  if (rx_idx_q == BIT_LAST) rx_state_d = RX_STOP;
                  else                      rx_idx_d   = rx_idx_q + BIT_ONE;
               end else begin
                  rx_cnt_d = rx_cnt_q + TICK_ONE;
               end
            end
            RX_STOP: begin
               // Return straight to IDLE at the stop-bit centre so a following start edge is caught.
               if (rx_cnt_q == TICK_LAST) begin
                  rx_cnt_d   = '0;
                  rx_state_d = RX_IDLE;
                  rx_done    = 1'b1;
               end else begin
                  rx_cnt_d = rx_cnt_q + TICK_ONE;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   // A completing byte takes priority over a simultaneous read acknowledge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out    <= '0;
         rxrdy       <= 1'b0;
         framing_err <= 1'b0;
         overflow    <= 1'b0;
      end else if (rx_done) begin
         data_out    <= rx_shift_q;
         rxrdy       <= 1'b1;
         framing_err <= ~rx_s;
         overflow    <= oen & (overflow | rxrdy);
      end else if (!oen) begin
         rxrdy       <= 1'b0;
         framing_err <= 1'b0;
         overflow    <= 1'b0;
      end
   end

   // ---------------- TX path ----------------
   uart_tx_state_t         tx_state_q, tx_state_d;
   logic [TICK_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [BIT_IDX_W-1:0]   tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
   logic                   tx_arm_q, tx_arm_d;
   logic                   tx_d;
   logic                   wen_q;
   logic                   tx_load;

   assign txrdy   = (tx_state_q == TX_IDLE);
   assign tx_load = wen_q & ~wen & txrdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wen_q      <= 1'b1;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_arm_q   <= 1'b0;
         tx         <= 1'b1;
      end else begin
         wen_q      <= wen;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_arm_q   <= tx_arm_d;
         tx         <= tx_d;
      end
   end

   // Every bit boundary lands on a tick; tx_arm marks START waiting for its first tick.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_arm_d   = tx_arm_q;
      tx_d       = tx;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (tx_load) begin
               tx_state_d = TX_START;
               tx_shift_d = data_in;
               tx_arm_d   = 1'b1;
               tx_cnt_d   = '0;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_arm_q) begin
                  tx_arm_d = 1'b0;
                  tx_d     = 1'b0;
                  tx_cnt_d = '0;
               end else if (tx_cnt_q == TICK_LAST) begin
                  tx_cnt_d   = '0;
                  tx_idx_d   = '0;
                  tx_d       = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                  tx_state_d = TX_DATA;
               end else begin
                  tx_cnt_d = tx_cnt_q + TICK_ONE;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_cnt_q == TICK_LAST) begin
                  tx_cnt_d = '0;
                  if (tx_idx_q == BIT_LAST) begin
                     tx_d       = 1'b1;
                     tx_state_d = TX_STOP;
                  end else begin
                     tx_idx_d   = tx_idx_q + BIT_ONE;
                     tx_d       = tx_shift_q[0];
                     tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q + TICK_ONE;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_cnt_q == TICK_LAST) begin
                  tx_cnt_d   = '0;
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_cnt_d = tx_cnt_q + TICK_ONE;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_core_8n1.sv
// Scoreboard bench for uart_core_8n1: directed RX/TX frames with expected
// results queued at stimulus time and compared by independent monitors.
module tb_uart_core_8n1;

   localparam int BIT_CLKS = 434;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [12:0] baud_val = 13'd26;
   logic [2:0]  baud_val_frac = 3'd1;
   logic        rx = 1'b1;
   logic        tx;
   logic [7:0]  data_in = 8'h00;
   logic        wen = 1'b1;
   logic        txrdy;
   logic [7:0]  data_out;
   logic        rxrdy;
   logic        oen = 1'b1;
   logic        framing_err;
   logic        overflow;

   always #5 clk = ~clk;

   uart_core_8n1 #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .baud_val     (baud_val),
      .baud_val_frac(baud_val_frac),
      .rx           (rx),
      .tx           (tx),
      .data_in      (data_in),
      .wen          (wen),
      .txrdy        (txrdy),
      .data_out     (data_out),
      .rxrdy        (rxrdy),
      .oen          (oen),
      .framing_err  (framing_err),
      .overflow     (overflow)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       ovf;
   } rx_exp_t;

   rx_exp_t    rx_q[$];
   logic [7:0] tx_q[$];
   bit         tx_abort = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input logic [7:0] d, input logic fe, input logic ov);
      rx_exp_t e;
      e.data = d;
      e.ferr = fe;
      e.ovf  = ov;
      rx_q.push_back(e);
   endtask

   // Drives the first nbits of a frame (start, 8 data LSB first, stop); caller sits at posedge+1.
   task automatic rx_bits(input logic [7:0] b, input logic stop_bit, input int nbits);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         rx = frame[i];
         repeat (BIT_CLKS) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_tick(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!dut.u_baud.tick && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!dut.u_baud.tick) begin
         checks++;
         failures++;
         $display("FAIL baud_tick_timeout: no tick within 100 clocks");
      end
      c = cyc;
   endtask

   task automatic wait_rxrdy(input string name, input int limit);
      int n;
      n = 0;
      while (!rxrdy && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!rxrdy) begin
         checks++;
         failures++;
         $display("FAIL %s: rxrdy not seen within %0d clocks", name, limit);
      end
   endtask

   task automatic wait_txrdy(input string name, input int limit);
      int n;
      n = 0;
      while (!txrdy && n < limit) begin
         step();
         n++;
      end
      if (!txrdy) begin
         checks++;
         failures++;
         $display("FAIL %s: txrdy not seen within %0d clocks", name, limit);
      end
   endtask

   // RX monitor: a byte is presented when rxrdy rises or overflow rises.
   logic    rxrdy_p = 1'b0;
   logic    ovf_p = 1'b0;
   rx_exp_t mon_e;

   always @(negedge clk) begin
      if (reset_n && ((rxrdy && !rxrdy_p) || (overflow && !ovf_p))) begin
         if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got byte 0x%0h with nothing expected", data_out);
         end else begin
            mon_e = rx_q.pop_front();
            check("rx_data", data_out, mon_e.data);
            check("rx_framing_err", framing_err, mon_e.ferr);
            check("rx_overflow", overflow, mon_e.ovf);
         end
      end
      rxrdy_p <= rxrdy;
      ovf_p   <= overflow;
   end

   // TX monitor: samples each bit centre after a falling tx, then times txrdy.
   task automatic tx_capture();
      logic [9:0] bits;
      int         n;
      bit         done;
      logic [7:0] exp_b;
      bits = '0;
      n    = 0;
      done = 1'b0;
      while (n < 5000 && !done) begin
         @(negedge clk);
         n++;
         for (int k = 0; k < 10; k++)
            if (n == 217 + BIT_CLKS * k) bits[k] = tx;
         if (txrdy) done = 1'b1;
      end
      if (tx_abort) begin
         tx_abort = 1'b0;
      end else if (!done) begin
         checks++;
         failures++;
         $display("FAIL tx_frame_timeout: txrdy not raised within 5000 clocks");
      end else if (tx_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL tx_unexpected: got frame 0x%0h with nothing expected", bits[8:1]);
      end else begin
         exp_b = tx_q.pop_front();
         check("tx_start_bit", bits[0], 1'b0);
         check("tx_data", bits[8:1], exp_b);
         check("tx_stop_bit", bits[9], 1'b1);
         check_range("tx_busy_len", n, 4340, 4342);
      end
   endtask

   initial begin
      forever begin
         @(negedge tx);
         if (reset_n) tx_capture();
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t[9];
      int n28;
      int n;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_txrdy", txrdy, 1'b1);
      check("rst_rxrdy", rxrdy, 1'b0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_framing_err", framing_err, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      reset_n = 1'b1;
      step();

      // Baud 26 + 1/8: eight periods sum to 217 with a single 28-clock period
      for (int i = 0; i < 9; i++) wait_tick(t[i]);
      n28 = 0;
      for (int i = 0; i < 8; i++) if (t[i+1] - t[i] == 28) n28++;
      check("baud_8_periods", t[8] - t[0], 217);
      check("baud_long_periods", n28, 1);

      // Baud 3 + 0: a tick every 4 clocks once the new value is reloaded
      step();
      baud_val      = 13'd3;
      baud_val_frac = 3'd0;
      wait_tick(t[0]);
      wait_tick(t[0]);
      for (int i = 1; i < 5; i++) wait_tick(t[i]);
      for (int i = 0; i < 4; i++) check("baud_fast_period", t[i+1] - t[i], 4);
      step();
      reset_n       = 1'b0;
      baud_val      = 13'd26;
      baud_val_frac = 3'd1;
      step();
      reset_n = 1'b1;
      repeat (5) step();

      // Single byte 0xA5 then a 4-clock read acknowledge
      push_rx(8'hA5, 1'b0, 1'b0);
      rx_bits(8'hA5, 1'b1, 10);
      check("rx_a5_rxrdy", rxrdy, 1'b1);
      oen = 1'b0;
      step();
      @(negedge clk);
      check("rx_oen_clear", rxrdy, 1'b0);
      repeat (3) step();
      oen = 1'b1;
      repeat (5) step();

      // Four back-to-back frames, each read as soon as it is presented
      push_rx(8'hDE, 1'b0, 1'b0);
      push_rx(8'hAD, 1'b0, 1'b0);
      push_rx(8'hBE, 1'b0, 1'b0);
      push_rx(8'hEF, 1'b0, 1'b0);
      fork
         begin
            rx_bits(8'hDE, 1'b1, 10);
            rx_bits(8'hAD, 1'b1, 10);
            rx_bits(8'hBE, 1'b1, 10);
            rx_bits(8'hEF, 1'b1, 10);
         end
         begin
            for (int i = 0; i < 4; i++) begin
               wait_rxrdy("b2b_rxrdy", 6000);
               step();
               oen = 1'b0;
               step();
               oen = 1'b1;
            end
         end
      join
      repeat (5) step();

      // Two unread frames: the second overwrites and flags overflow
      push_rx(8'h11, 1'b0, 1'b0);
      push_rx(8'h22, 1'b0, 1'b1);
      rx_bits(8'h11, 1'b1, 10);
      rx_bits(8'h22, 1'b1, 10);
      repeat (5) step();
      check("ovf_data_out", data_out, 8'h22);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_rxrdy", rxrdy, 1'b1);
      oen = 1'b0;
      repeat (4) step();
      oen = 1'b1;
      @(negedge clk);
      check("ovf_read_rxrdy", rxrdy, 1'b0);
      check("ovf_read_flag", overflow, 1'b0);
      step();

      // 10-clock low glitch is a false start and changes nothing
      rx = 1'b0;
      repeat (10) step();
      rx = 1'b1;
      repeat (2 * BIT_CLKS) step();
      check("glitch_rxrdy", rxrdy, 1'b0);
      check("glitch_data_out", data_out, 8'h22);

      // Stop bit forced low: byte delivered with framing error, left unread
      push_rx(8'h3C, 1'b1, 1'b0);
      rx_bits(8'h3C, 1'b0, 10);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) step();
      check("ferr_data_out", data_out, 8'h3C);
      check("ferr_flag", framing_err, 1'b1);

      // Transmit 0x5A with wen held low for 5 clocks
      tx_q.push_back(8'h5A);
      data_in = 8'h5A;
      wen     = 1'b0;
      step();
      check("tx_txrdy_drop", txrdy, 1'b0);
      fork
         begin
            repeat (4) step();
            wen = 1'b1;
         end
         begin
            n = 0;
            while (tx === 1'b1 && n < 100) begin
               step();
               n++;
            end
            check_range("tx_start_lag", n, 1, 29);
         end
      join
      repeat (1000) step();
      // A second falling edge mid-frame must be ignored
      wen = 1'b0;
      data_in = 8'hFF;
      repeat (3) step();
      check("tx_midframe_busy", txrdy, 1'b0);
      wait_txrdy("tx_done", 5000);
      wen = 1'b1;
      repeat (2 * BIT_CLKS) step();
      check("tx_no_retrigger_txrdy", txrdy, 1'b1);
      check("tx_idle_level", tx, 1'b1);
      check("tx_queue_drained", tx_q.size(), 0);

      // Reset in the middle of both an RX and a TX frame
      data_in = 8'h77;
      wen     = 1'b0;
      step();
      wen      = 1'b1;
      tx_abort = 1'b1;
      rx_bits(8'h96, 1'b1, 5);
      check("pre_reset_rxrdy", rxrdy, 1'b1);
      check("pre_reset_txrdy", txrdy, 1'b0);
      reset_n = 1'b0;
      #2;
      check("mid_reset_tx", tx, 1'b1);
      check("mid_reset_txrdy", txrdy, 1'b1);
      check("mid_reset_rxrdy", rxrdy, 1'b0);
      check("mid_reset_framing_err", framing_err, 1'b0);
      step();
      rx      = 1'b1;
      reset_n = 1'b1;
      repeat (2 * BIT_CLKS) step();

      // Clean frames in both directions after the reset
      push_rx(8'h96, 1'b0, 1'b0);
      tx_q.push_back(8'hC3);
      data_in = 8'hC3;
      wen     = 1'b0;
      step();
      wen = 1'b1;
      rx_bits(8'h96, 1'b1, 10);
      wait_txrdy("tx_clean_done", 6000);
      repeat (20) step();
      oen = 1'b0;
      step();
      oen = 1'b1;
      repeat (5) step();

      check("rx_queue_drained", rx_q.size(), 0);
      check("tx_queue_final", tx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
